// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset main controller.
//
// Contents:
//   state_e          - controller state encoding
//   OPC_*            - supported major opcodes
//   ALUOP_*          - aluop encodings consumed by the ALU-control block
//   SRCB_*           - alu_src_b mux select encodings
//   WAIT_CNT_W       - width of the memory wait counter (covers MEM_WAIT_MAX up to 255)
//   is_req_state()   - true for states that issue a memory request
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StWbR,
        StMemAddr,
        StMemRd,
        StWbMem,
        StMemWr,
        StBranch,
        StTrap
    } state_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam int unsigned WAIT_CNT_W = 8;

    function automatic logic is_req_state(state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on mem_ready and flags a timeout.
//
// Parameters:
//   MEM_WAIT_MAX - number of unanswered request cycles tolerated (1..255)
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   req      in   memory request currently asserted
//   ready    in   memory completes the request this cycle
//   expired  out  counter has reached MEM_WAIT_MAX (registered, Moore)
//
// The counter is zero whenever no request is outstanding, so it is always
// clear on entry to a request state. While expired is high the controller
// drops mem_req, which clears the counter again on the following edge.
module mem_wait_timer
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req || ready) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == WAIT_CNT_W'(MEM_WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of a multi-cycle RV32I-subset core.
//
// Supports R-type ALU ops, lw, sw and beq. Produces the datapath enables and
// the aluop/funccode pair consumed by the ALU-control block.
//
// Build option:
//   ILLEGAL_TRAP_EN - when defined, an unsupported opcode locks the controller
//                     in a trap state with illegal = 1 until reset; otherwise
//                     such an instruction is skipped as a NOP.
//
// Parameters:
//   MEM_WAIT_MAX - cycles to wait for mem_ready before signalling bus_err
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   mem_rdata    memory read data (instruction in fetch)
//   mem_ready    memory completes the current request
//   zero         ALU zero flag (beq resolution)
//   mem_req      memory request
//   mem_we       memory write (sw)
//   ir_write     load instruction register
//   pc_write     update PC
//   pc_src       PC source: 0 = ALU result, 1 = branch-target register
//   alu_src_a    0 = PC, 1 = rs1
//   alu_src_b    0 = rs2, 1 = const 4, 2 = imm
//   aluop        00 add, 01 sub, 10 use funccode
//   funccode     {instr[31:25], instr[14:12]} of the latched instruction
//   reg_write    regfile write enable
//   mem_to_reg   writeback from memory data
//   bus_err      one-cycle pulse on memory timeout
//   illegal      trap indication (tied 0 without ILLEGAL_TRAP_EN)
//   instret      retired-instruction counter
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  aluop,
    output logic [9:0]  funccode,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        bus_err,
    output logic        illegal,
    output logic [31:0] instret
);

    state_e      state_q;
    state_e      state_d;
    // Low only in the first cycle after reset: keeps every output quiet there.
    logic        run_q;
    logic [6:0]  opcode_q;
    logic [9:0]  funccode_q;
    logic [31:0] instret_q;

    logic        expired;
    logic        retire;
    logic        unused_rdata;

    assign unused_rdata = ^{mem_rdata[24:15], mem_rdata[11:7]};

    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (mem_req),
        .ready   (mem_ready),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Latched instruction fields and retirement counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode_q   <= '0;
            funccode_q <= '0;
            instret_q  <= '0;
        end else begin
            if (ir_write) begin
                opcode_q   <= mem_rdata[6:0];
                funccode_q <= {mem_rdata[31:25], mem_rdata[14:12]};
            end
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Next-state logic. A timeout takes priority over a late mem_ready,
    // because mem_req is already dropped in the expired cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (ir_write) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                unique case (opcode_q)
                    OPC_RTYPE:           state_d = StExecR;
                    OPC_LOAD, OPC_STORE: state_d = StMemAddr;
                    OPC_BRANCH:          state_d = StBranch;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = StTrap;
`else
                        state_d = StFetch;
`endif
                    end
                endcase
            end
            StExecR:   state_d = StWbR;
            StWbR:     state_d = StFetch;
            StMemAddr: state_d = (opcode_q == OPC_LOAD) ? StMemRd : StMemWr;
            StMemRd: begin
                if (expired) begin
                    state_d = StFetch;
                end else if (mem_ready) begin
                    state_d = StWbMem;
                end
            end
            StWbMem:   state_d = StFetch;
            StMemWr: begin
                if (expired || mem_ready) begin
                    state_d = StFetch;
                end
            end
            StBranch:  state_d = StFetch;
            StTrap: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = StTrap;
`else
                state_d = StFetch;
`endif
            end
            default:   state_d = StFetch;
        endcase
    end

    // Output decode (Moore, except fetch enables gated by mem_ready and
    // the branch PC write gated by zero).
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        aluop      = ALUOP_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (run_q) begin
                    mem_req   = !expired;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = !expired && mem_ready;
                    pc_write  = !expired && mem_ready;
                end
            end
            StDecode: begin
                alu_src_b = SRCB_IMM;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_FUNC;
            end
            StWbR: begin
                reg_write = 1'b1;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            StMemRd: begin
                mem_req = !expired;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_req = !expired;
                mem_we  = !expired;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_SUB;
                pc_src    = 1'b1;
                pc_write  = zero;
            end
            default: begin
            end
        endcase
    end

    // The counter only reaches its limit inside a request state.
    assign bus_err = expired;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == StTrap);
`else
    assign illegal = 1'b0;
`endif

    assign retire = (state_q == StWbR) || (state_q == StWbMem) || (state_q == StBranch) ||
                    ((state_q == StMemWr) && mem_req && mem_ready);

    assign funccode = funccode_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Stimulus and expected outputs are
// generated together, one entry per clock cycle, from an instruction-level
// description (class, memory latencies, zero flag), then replayed and compared.
module tb_multicycle_ctrl;

    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b, aluop;
    logic [9:0]  funccode;
    logic        reg_write, mem_to_reg, bus_err, illegal;
    logic [31:0] instret;

    multicycle_ctrl #(
        .MEM_WAIT_MAX (MAXW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .funccode   (funccode),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .bus_err    (bus_err),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        chk;
        logic [31:0] rdata;
        logic        ready;
        logic        zero;
        logic        req, we, irw, pcw, pcs, srca;
        logic [1:0]  srcb, aluop;
        logic [9:0]  func;
        logic        rw, m2r, berr, ill;
        logic [31:0] iret;
    } cyc_t;

    cyc_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [9:0]  func_m  = '0;
    logic [31:0] iret_m  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A cycle where no enable is expected; unused inputs are randomised.
    function automatic cyc_t blank();
        cyc_t c;
        c.rst   = 1'b1;
        c.chk   = 1'b1;
        c.rdata = $urandom;
        c.ready = 1'($urandom_range(0, 1));
        c.zero  = 1'($urandom_range(0, 1));
        c.req = 0; c.we = 0; c.irw = 0; c.pcw = 0; c.pcs = 0; c.srca = 0;
        c.srcb = 2'd0; c.aluop = 2'd0;
        c.rw = 0; c.m2r = 0; c.berr = 0; c.ill = 0;
        c.func = func_m;
        c.iret = iret_m;
        return c;
    endfunction

    task automatic push_reset();
        cyc_t c;
        c = blank();
        c.rst = 1'b0;
        c.chk = 1'b0;
        q.push_back(c);
        func_m = '0;
        iret_m = '0;
        q.push_back(blank());  // first cycle after reset: everything quiet
    endtask

    // One fetch attempt; waits >= MAXW means the memory never answers.
    task automatic fetch(input logic [31:0] instr, input int waits, output bit ok);
        cyc_t c;
        for (int i = 0; i < waits && i < int'(MAXW); i++) begin
            c = blank();
            c.ready = 1'b0;
            c.req = 1; c.srcb = 2'd1;
            q.push_back(c);
        end
        if (waits >= int'(MAXW)) begin
            c = blank();
            c.srcb = 2'd1; c.berr = 1;
            q.push_back(c);
            ok = 1'b0;
        end else begin
            c = blank();
            c.ready = 1'b1; c.rdata = instr;
            c.req = 1; c.irw = 1; c.pcw = 1; c.srcb = 2'd1;
            q.push_back(c);
            func_m = {instr[31:25], instr[14:12]};
            ok = 1'b1;
        end
    endtask

    task automatic data_phase(input logic we, input int waits, output bit ok);
        cyc_t c;
        for (int i = 0; i < waits && i < int'(MAXW); i++) begin
            c = blank();
            c.ready = 1'b0;
            c.req = 1; c.we = we;
            q.push_back(c);
        end
        if (waits >= int'(MAXW)) begin
            c = blank();
            c.berr = 1;
            q.push_back(c);
            ok = 1'b0;
        end else begin
            c = blank();
            c.ready = 1'b1;
            c.req = 1; c.we = we;
            q.push_back(c);
            ok = 1'b1;
        end
    endtask

    task automatic add_instr(input logic [31:0] instr, input int fwait, input int dwait,
                             input logic z);
        cyc_t c;
        bit   ok;
        fetch(instr, fwait, ok);
        if (!ok) fetch(instr, 0, ok);
        c = blank(); c.srcb = 2'd2; q.push_back(c);  // decode
        case (instr[6:0])
            7'b0110011: begin
                c = blank(); c.srca = 1; c.srcb = 2'd0; c.aluop = 2'b10; q.push_back(c);
                c = blank(); c.rw = 1; q.push_back(c);
                iret_m++;
            end
            7'b0000011: begin
                c = blank(); c.srca = 1; c.srcb = 2'd2; q.push_back(c);
                data_phase(1'b0, dwait, ok);
                if (ok) begin
                    c = blank(); c.rw = 1; c.m2r = 1; q.push_back(c);
                    iret_m++;
                end
            end
            7'b0100011: begin
                c = blank(); c.srca = 1; c.srcb = 2'd2; q.push_back(c);
                data_phase(1'b1, dwait, ok);
                if (ok) iret_m++;
            end
            7'b1100011: begin
                c = blank();
                c.zero = z; c.srca = 1; c.srcb = 2'd0; c.aluop = 2'b01; c.pcs = 1; c.pcw = z;
                q.push_back(c);
                iret_m++;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) begin
                    c = blank(); c.ill = 1; q.push_back(c);
                end
`endif
            end
        endcase
    endtask

    // One unanswered fetch cycle, so the last retirement becomes visible.
    task automatic pad();
        cyc_t c;
        c = blank();
        c.ready = 1'b0; c.req = 1; c.srcb = 2'd1;
        q.push_back(c);
    endtask

    task automatic run_all();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst_n     = c.rst;
            mem_rdata = c.rdata;
            mem_ready = c.ready;
            zero      = c.zero;
            @(negedge clk);
            if (c.chk) begin
                check("mem_req",    32'(mem_req),    32'(c.req));
                check("mem_we",     32'(mem_we),     32'(c.we));
                check("ir_write",   32'(ir_write),   32'(c.irw));
                check("pc_write",   32'(pc_write),   32'(c.pcw));
                check("pc_src",     32'(pc_src),     32'(c.pcs));
                check("alu_src_a",  32'(alu_src_a),  32'(c.srca));
                check("alu_src_b",  32'(alu_src_b),  32'(c.srcb));
                check("aluop",      32'(aluop),      32'(c.aluop));
                check("funccode",   32'(funccode),   32'(c.func));
                check("reg_write",  32'(reg_write),  32'(c.rw));
                check("mem_to_reg", 32'(mem_to_reg), 32'(c.m2r));
                check("bus_err",    32'(bus_err),    32'(c.berr));
                check("illegal",    32'(illegal),    32'(c.ill));
                check("instret",    instret,         c.iret);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [6:0]  opc;
        int          cls;
        int          fw;
        int          dw;

        // add, zero-wait
        push_reset();
        add_instr(32'h00B50533, 0, 0, 1'b0);
        run_all();
        check("lit_add_reg_write", 32'(reg_write), 32'd1);
        check("lit_add_funccode", 32'(funccode), 32'd0);
        pad(); run_all();
        check("lit_add_instret", instret, 32'd1);

        // sub then and
        push_reset();
        add_instr(32'h40B50533, 0, 0, 1'b0);
        run_all();
        check("lit_sub_funccode", 32'(funccode), 32'd256);
        add_instr(32'h00B57533, 0, 0, 1'b0);
        run_all();
        check("lit_and_funccode", 32'(funccode), 32'd7);
        pad(); run_all();
        check("lit_subadd_instret", instret, 32'd2);

        // lw with 3 wait cycles, then sw
        push_reset();
        add_instr(32'h00052283, 0, 3, 1'b0);
        run_all();
        check("lit_lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        add_instr(32'h00552023, 0, 0, 1'b0);
        run_all();
        check("lit_sw_mem_we", 32'(mem_we), 32'd1);
        pad(); run_all();
        check("lit_lwsw_instret", instret, 32'd2);

        // beq taken, then not taken
        push_reset();
        add_instr(32'h00B50463, 0, 0, 1'b1);
        run_all();
        check("lit_beq1_pc_write", 32'(pc_write), 32'd1);
        check("lit_beq1_pc_src", 32'(pc_src), 32'd1);
        add_instr(32'h00B50463, 0, 0, 1'b0);
        run_all();
        check("lit_beq0_pc_write", 32'(pc_write), 32'd0);
        check("lit_beq0_aluop", 32'(aluop), 32'd1);

        // fetch timeout
        push_reset();
        begin
            bit ok;
            fetch(32'h00B50533, int'(MAXW), ok);
        end
        run_all();
        check("lit_to_bus_err", 32'(bus_err), 32'd1);
        check("lit_to_mem_req", 32'(mem_req), 32'd0);
        check("lit_to_instret", instret, 32'd0);
        pad(); run_all();
        check("lit_retry_mem_req", 32'(mem_req), 32'd1);
        check("lit_retry_bus_err", 32'(bus_err), 32'd0);

        // randomised instruction stream
        push_reset();
        for (int n = 0; n < 250; n++) begin
`ifdef ILLEGAL_TRAP_EN
            cls = $urandom_range(0, 3);
`else
            cls = $urandom_range(0, 4);
`endif
            case (cls)
                0:       opc = 7'b0110011;
                1:       opc = 7'b0000011;
                2:       opc = 7'b0100011;
                3:       opc = 7'b1100011;
                default: opc = 7'h7F;
            endcase
            r  = $urandom;
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXW) : 0;
            dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXW) : 0;
            add_instr({r[31:7], opc}, fw, dw, 1'($urandom_range(0, 1)));
        end
        run_all();

        // unsupported opcode
        push_reset();
        add_instr(32'h00B50533, 0, 0, 1'b0);
        add_instr(32'h0000007F, 0, 0, 1'b0);
        run_all();
`ifdef ILLEGAL_TRAP_EN
        check("lit_trap_illegal", 32'(illegal), 32'd1);
        check("lit_trap_instret", instret, 32'd1);
        push_reset();
        run_all();
        check("lit_trap_cleared", 32'(illegal), 32'd0);
        check("lit_trap_rst_instret", instret, 32'd0);
`else
        pad(); run_all();
        check("lit_nop_illegal", 32'(illegal), 32'd0);
        check("lit_nop_instret", instret, 32'd1);
        check("lit_nop_fetch", 32'(mem_req), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RV32I-subset main control FSM; the producer side of the ALU-control interface (aluop, funccode) consumed by the existing ALU/ALU-control top.
- Fetches over a simple ready/req memory handshake, decodes opcode, sequences datapath enables, and resolves branches from the ALU zero flag.
- Sits between instruction/data memory and the datapath (PC, IR, regfile, ALU muxes).

Parameters:
- MEM_WAIT_MAX, 16, max cycles spent waiting for mem_ready before bus_err; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mem_rdata  in  32  memory read data; sampled as instruction in FETCH
- mem_ready  in  1  memory completes the current request this cycle
- zero  in  1  ALU zero flag
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (sw), 0 = read
- ir_write  out  1  load IR (1-cycle pulse)
- pc_write  out  1  unconditional PC update
- pc_src  out  1  0 = ALU result (PC+4), 1 = branch-target register
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  0 = rs2, 1 = const 4, 2 = imm
- aluop  out  2  00 add, 01 sub (beq), 10 use funccode
- funccode  out  10  {instr[31:25], instr[14:12]} of latched instruction
- reg_write  out  1  regfile write enable
- mem_to_reg  out  1  writeback source: 1 = memory data
- bus_err  out  1  1-cycle pulse on memory timeout
- illegal  out  1  see Optional Feature
- instret  out  32  retired-instruction counter

Behaviour:
- Reset (rst_n low at clk edge): state = FETCH, all 1-bit outputs 0, alu_src_b = 0, aluop = 0, funccode = 0, instret = 0, wait counter = 0. Reset mid-request abandons it; mem_req is low in the first cycle after reset.
- Outputs are Moore, decoded from the state register plus latched opcode/funct fields. ir_write and pc_write are gated by mem_ready in FETCH.
- FETCH:
  - mem_req = 1, mem_we = 0, alu_src_a = 0, alu_src_b = 1, aluop = 00.
  - On mem_ready: ir_write = 1, pc_write = 1, opcode and funccode latched from mem_rdata; go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 2, aluop = 00 (branch target computed and held externally). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0000011, 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - other -> ILLEGAL handling
- EXEC_R: alu_src_a = 1, alu_src_b = 0, aluop = 10 -> WB_R.
- WB_R: reg_write = 1, mem_to_reg = 0 -> FETCH; instret increments.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, aluop = 00 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req = 1; on mem_ready go to WB_MEM.
- WB_MEM: reg_write = 1, mem_to_reg = 1 -> FETCH; instret increments.
- MEM_WR: mem_req = 1, mem_we = 1; on mem_ready go to FETCH; instret increments.
- BRANCH: alu_src_a = 1, alu_src_b = 0, aluop = 01, pc_src = 1, pc_write = zero -> FETCH; instret increments.
- Zero-wait latencies: R-type 4 cycles, lw 5, sw 4, beq 3.
- Wait counter:
  - Clears on entering any request state; increments each cycle mem_req = 1 && !mem_ready.
  - If it reaches MEM_WAIT_MAX: bus_err pulses for 1 cycle, request is dropped, go to FETCH, instret does not increment. The PC was not written, so the fetch is retried.
- mem_ready while mem_req = 0 is ignored.
- instret wraps from 0xFFFFFFFF to 0.
- funccode holds its value until the next ir_write.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE enters TRAP. TRAP is terminal, drives all enables 0, and holds illegal = 1 until reset.
- Undefined: an unsupported opcode is a NOP; DECODE -> FETCH, instret does not increment, and illegal is tied 0.

Decomposition:
- Shared package holds:
  - state enum;
  - opcode constants (OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH);
  - aluop encodings (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNC = 10);
  - alu_src_b encodings.
- One sub-module, mem_wait_timer (counter plus timeout compare, parameterised by MEM_WAIT_MAX); FSM and output decode stay in the top.

Test Plan:
- add 0x00B50533, mem_ready immediate -> funccode = 0, aluop = 10 in EXEC_R; reg_write in cycle 4; instret = 1.
- sub 0x40B50533 then and 0x00B57533 -> funccode = 256, then 7, with aluop = 10; instret = 2.
- lw 0x00052283 with mem_ready delayed 3 cycles in MEM_RD -> mem_req held for 4 cycles, then WB_MEM with mem_to_reg = 1; sw 0x00552023 -> mem_we = 1 only in MEM_WR.
- beq 0x00B50463 with zero = 1, then again with zero = 0 -> pc_write = 1 with pc_src = 1, then pc_write = 0; aluop = 01 both times.
- MEM_WAIT_MAX = 4, mem_ready never asserted in FETCH -> bus_err pulses after 4 wait cycles, back to FETCH, instret unchanged.
- Opcode 0x7F -> with ILLEGAL_TRAP_EN: illegal = 1 and held; rst_n low for 1 clock clears it. Without the macro: returns to FETCH and instret is unchanged.
